// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the address/word widths, buffer depth, buffer entry layout and FSM states.
package fetch_pkg;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake: the fetch stage presents the buffer head, decode accepts it.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int PC_W = fetch_pkg::PC_W
) ();

  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;

  modport master (output id_valid, id_instr, id_pc, input id_ready);
  modport slave  (input id_valid, id_instr, id_pc, output id_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch buffer: DEPTH entries, flush clears it, head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = fetch_pkg::DEPTH,
  parameter int W     = fetch_pkg::PC_W + INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_fifo: DEPTH must be 2 or 4");
  end

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push writes, so full+pop still accepts a push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[tail] <= din;
  end

  assign dout = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/RUN fetch FSM, push counter and fetch buffer.
// Redirects flush the buffer and reload the PC ahead of any push or pop that cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = fetch_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_addr,
  fetch_if.master            id,
  output logic [15:0]        fetch_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_t                state, state_nx;
  logic [PC_W-1:0]             pc;
  logic                        push, pop;
  logic [CNT_W-1:0]            count;
  logic [PC_W+INSTR_W-1:0]     head_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      IDLE: if (fetch_en) state_nx = RUN;
      RUN: begin
        push = !redirect_valid && ((count != FULL_CNT) || pop);
        if (!fetch_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop = id.id_valid && id.id_ready;

  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_addr;
    else if (push)           pc <= pc + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                               fetch_cnt <= '0;
    else if (push && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({pc, imem_instr}),
    .dout  (head_q),
    .count (count)
  );

  assign imem_addr              = pc;
  assign id.id_valid            = (count != '0);
  assign {id.id_pc, id.id_instr} = head_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expected deliveries go into a queue, a negedge monitor
// checks each id handshake against it. Memory word k holds the value k.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst, fetch_en, redirect_valid;
  logic [PC_W-1:0]   imem_addr, redirect_addr;
  logic [31:0]       imem_instr;
  logic [15:0]       fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;
  fetch_entry_t sb[$];

  fetch_if #(.PC_W(PC_W)) id ();

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .id             (id),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;
  assign imem_instr = 32'(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input int pc);
    fetch_entry_t e;
    e.pc    = PC_W'(pc);
    e.instr = 32'(pc);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && id.id_valid && id.id_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc %0h expected none", id.id_pc);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        chk("deliver_pc", 32'(id.id_pc), 32'(e.pc));
        chk("deliver_instr", id.id_instr, e.instr);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    id.id_ready = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("rst_valid", 32'(id.id_valid), 0);
    chk("rst_pc", 32'(id.id_pc), 0);
    chk("rst_instr", id.id_instr, 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 0);

    // Streaming from reset: first cycle idle, then 0,1,2,... back to back
    cyc(1);
    rst = 1'b0; fetch_en = 1'b1; id.id_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_pc(k);
    @(negedge clk);
    chk("first_cycle_valid", 32'(id.id_valid), 0);
    cyc(8);
    id.id_ready = 1'b0; rst = 1'b1;

    // Backpressure: stall four cycles after the first push
    cyc(1);
    rst = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 4; k++) expect_pc(k);
    cyc(4);
    @(negedge clk);
    chk("stall_valid", 32'(id.id_valid), 1);
    chk("stall_head_pc", 32'(id.id_pc), 0);
    chk("stall_head_instr", id.id_instr, 0);
    chk("stall_pc_hold", 32'(imem_addr), 2);
    chk("stall_fetch_cnt", 32'(fetch_cnt), 2);
    cyc(1);
    id.id_ready = 1'b1;
    cyc(4);
    id.id_ready = 1'b0;
    @(negedge clk);
    chk("full_head_pc", 32'(id.id_pc), 4);
    chk("full_fetch_cnt", 32'(fetch_cnt), 6);

    // Reset with a full buffer
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(id.id_valid), 0);
    chk("midrst_imem_addr", 32'(imem_addr), 0);
    chk("midrst_fetch_cnt", 32'(fetch_cnt), 0);
    chk("midrst_pc", 32'(id.id_pc), 0);

    // Redirect to 0x40 with two entries buffered
    cyc(1);
    fetch_en = 1'b1;
    cyc(3);
    redirect_valid = 1'b1; redirect_addr = 7'h40;
    expect_pc(8'h40); expect_pc(8'h41);
    @(negedge clk);
    chk("pre_redir_valid", 32'(id.id_valid), 1);
    chk("pre_redir_cnt", 32'(fetch_cnt), 2);
    cyc(1);
    redirect_valid = 1'b0; id.id_ready = 1'b1;
    @(negedge clk);
    chk("redir_flush_valid", 32'(id.id_valid), 0);
    chk("redir_imem_addr", 32'(imem_addr), 32'h40);
    chk("redir_cnt_hold", 32'(fetch_cnt), 2);

    // Redirect near the top of memory: address wraps 0x7F -> 0x00
    cyc(3);
    redirect_valid = 1'b1; redirect_addr = 7'h7E; id.id_ready = 1'b0;
    expect_pc(8'h7E); expect_pc(8'h7F); expect_pc(0); expect_pc(1);
    expect_pc(2); expect_pc(3);
    cyc(1);
    redirect_valid = 1'b0; id.id_ready = 1'b1;
    cyc(5);
    id.id_ready = 1'b0;

    // Drop fetch_en with two entries buffered, then drain
    cyc(1);
    fetch_en = 1'b0;
    @(negedge clk);
    chk("dis_head_pc", 32'(id.id_pc), 2);
    chk("dis_imem_addr", 32'(imem_addr), 4);
    chk("dis_fetch_cnt", 32'(fetch_cnt), 11);
    cyc(1);
    id.id_ready = 1'b1;
    cyc(2);
    redirect_valid = 1'b1; redirect_addr = 7'h10;
    @(negedge clk);
    chk("drained_valid", 32'(id.id_valid), 0);
    chk("drained_pc", 32'(id.id_pc), 0);
    chk("drained_instr", id.id_instr, 0);
    chk("drained_pc_hold", 32'(imem_addr), 4);
    chk("drained_fetch_cnt", 32'(fetch_cnt), 11);

    // Redirect while idle still loads the PC
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("idle_redir_addr", 32'(imem_addr), 32'h10);
    chk("idle_redir_valid", 32'(id.id_valid), 0);
    chk("idle_redir_cnt", 32'(fetch_cnt), 11);
    cyc(2);
    chk("scoreboard_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, 7, word-address width matching the instruction memory depth of 128 words.
REQ-002 Parameter: RESET_PC, 0, PC value loaded on reset.
REQ-003 Parameter: DEPTH, 2, fetch-buffer entries; legal values are powers of two from 2 to 4.
REQ-004 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: fetch_en  in  1  allows new fetches while high.
REQ-007 Port: imem_addr  out  PC_W  word address to the instruction memory (combinational read).
REQ-008 Port: imem_instr  in  32  instruction word returned for imem_addr in the same cycle.
REQ-009 Port: redirect_valid  in  1  branch/jump taken; flushes the buffer.
REQ-010 Port: redirect_addr  in  PC_W  new fetch address.
REQ-011 Port: id_valid  out  1  buffer head holds a valid instruction.
REQ-012 Port: id_ready  in  1  decode accepts the head this cycle.
REQ-013 Port: id_instr  out  32  head instruction word.
REQ-014 Port: id_pc  out  PC_W  address the head instruction was fetched from.
REQ-015 Port: fetch_cnt  out  16  count of instructions pushed, saturating at 0xFFFF.

Function
REQ-016 FSM states: IDLE and RUN; IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; no other transitions.
REQ-017 imem_addr shall equal the PC register at all times.
REQ-018 pop = id_valid && id_ready.
REQ-019 push = (state==RUN) && !redirect_valid && (count<DEPTH || pop).
REQ-020 On push: write {PC, imem_instr} at the tail, and set PC <= PC+1 modulo 2^PC_W (127 wraps to 0).
REQ-021 On pop: advance the head; push and pop in the same cycle leave count unchanged, including when the buffer is full.
REQ-022 Latency: an instruction pushed in cycle N is visible on id_* in cycle N+1; throughput is one instruction per cycle when id_ready=1.
REQ-023 id_valid = (count!=0); id_instr and id_pc are 0 when count==0.
REQ-024 Full (count==DEPTH, no pop): no push, PC holds, and the head is stable.
REQ-025 redirect_valid=1 has priority over push and pop: count<=0, PC<=redirect_addr, no push that cycle, and fetch_cnt unchanged; the first instruction from redirect_addr is visible no earlier than 2 cycles later.
REQ-026 A redirect in IDLE shall still flush the buffer and load PC.
REQ-027 fetch_en=0 stops pushes only; buffered entries remain poppable.
REQ-028 fetch_cnt increments by 1 on every push and holds at 0xFFFF.

Reset
REQ-029 While rst=1: state=IDLE, PC=RESET_PC, count=0, head/tail pointers=0, fetch_cnt=0, and therefore id_valid=0, id_instr=0, id_pc=0, imem_addr=RESET_PC.
REQ-030 Reset overrides redirect_valid, fetch_en and all in-flight operations in the same edge; buffered entries are discarded.

Structure
REQ-031 Shared package fetch_pkg holds PC_W, INSTR_W=32, DEPTH default, the fetch-entry struct {pc, instr}, and the state enum {IDLE, RUN}.
REQ-032 Buffer implemented as sub-module fetch_fifo (DEPTH entries, push/pop/flush, count); fetch_unit holds the FSM, PC, and counter.

Verification
REQ-033 Release reset with fetch_en=1, id_ready=1, memory word k = k: id_valid=0 in the first cycle, then id_pc/id_instr = 0,1,2,... on consecutive cycles.
REQ-034 Backpressure: id_ready=0 for 4 cycles after the first push -> count reaches 2; PC stays at 2 while stalled; id_pc holds 0; after release, 0,1,2,3 are delivered in order with no loss or duplication.
REQ-035 Redirect to 0x40 while the buffer holds 2 entries: id_valid=0 on the next cycle; the next delivered id_pc is 0x40, then 0x41; fetch_cnt is unchanged in the redirect cycle.
REQ-036 Wrap: redirect to 0x7E -> delivered id_pc sequence is 0x7E, 0x7F, 0x00, 0x01.
REQ-037 fetch_en dropped with 2 entries buffered -> both entries drain, no new pushes, and the PC holds.
REQ-038 Assert rst mid-stream with a full buffer -> next cycle id_valid=0, imem_addr=RESET_PC, fetch_cnt=0.
